// File: rtl/ucsbece154b_branch_resolve_if.sv
// ucsbece154b_branch_resolve_if: fetch-side metadata and update controls between gshare/BTB predictor and resolve unit
interface ucsbece154b_branch_resolve_if #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS = 5
);
  localparam int IDX = $clog2(NUM_BTB_ENTRIES);
  logic [31:0] pc_f_i;
  logic pred_taken_f_i;
  logic [31:0] pred_target_f_i;
  logic [NUM_GHR_BITS-1:0] pht_raddr_f_i;
  logic btb_we_o;
  logic [IDX-1:0] btb_waddr_o;
  logic [31:0] btb_wdata_o;
  logic pht_we_o;
  logic [NUM_GHR_BITS-1:0] pht_waddr_o;
  logic pht_increment_o;
  logic ghr_reset_o;
  modport master (
    output pc_f_i, pred_taken_f_i, pred_target_f_i, pht_raddr_f_i,
    input btb_we_o, btb_waddr_o, btb_wdata_o, pht_we_o, pht_waddr_o, pht_increment_o, ghr_reset_o
  );
  modport slave (
    input pc_f_i, pred_taken_f_i, pred_target_f_i, pht_raddr_f_i,
    output btb_we_o, btb_waddr_o, btb_wdata_o, pht_we_o, pht_waddr_o, pht_increment_o, ghr_reset_o
  );
endinterface

// File: rtl/ucsbece154b_branch_resolve.sv
// ucsbece154b_branch_resolve: carries prediction metadata F->D->E, resolves it in E and drives predictor updates
module ucsbece154b_branch_resolve #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS = 5
) (
  input  logic clk,
  input  logic reset_i,
  input  logic stallF_i,
  input  logic stallD_i,
  input  logic flushD_i,
  input  logic flushE_i,
  ucsbece154b_branch_resolve_if.slave bp,
  input  logic [6:0] op_e_i,
  input  logic taken_e_i,
  input  logic [31:0] target_e_i,
  output logic mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] branch_count_o,
  output logic [31:0] mispredict_count_o
);
  localparam int IDX = $clog2(NUM_BTB_ENTRIES);
  typedef struct packed {
    logic v;
    logic [31:0] pc;
    logic pt;
    logic [31:0] tgt;
    logic [NUM_GHR_BITS-1:0] pa;
  } meta_t;
  meta_t d, e;
  logic is_br, is_j, act_taken, tgt_miss;
  logic unused_stall_f;
  assign unused_stall_f = stallF_i;
  always_ff @(posedge clk) begin
    if (reset_i) d <= '0;
    else if (flushD_i) begin
      d.v <= 1'b0;
      d.pt <= 1'b0;
    end else if (!stallD_i) d <= '{1'b1, bp.pc_f_i, bp.pred_taken_f_i, bp.pred_target_f_i, bp.pht_raddr_f_i};
  end
  // a stalled D must not be resolved twice, so E takes a bubble instead of a copy
  always_ff @(posedge clk) begin
    if (reset_i || flushE_i || stallD_i) e <= '0;
    else e <= d;
  end
  always_comb begin
    is_br = op_e_i == 7'b1100011;
    is_j = op_e_i == 7'b1101111 || op_e_i == 7'b1100111;
    act_taken = is_br ? taken_e_i : is_j;
    tgt_miss = e.tgt != target_e_i;
    mispredict_o = e.v && (e.pt != act_taken || (act_taken && tgt_miss));
    redirect_pc_o = mispredict_o ? (act_taken ? target_e_i : e.pc + 32'd4) : '0;
    bp.btb_we_o = e.v && act_taken && (is_br || is_j) && (!e.pt || tgt_miss);
    bp.btb_waddr_o = e.v ? e.pc[IDX+1:2] : '0;
    bp.btb_wdata_o = e.v ? target_e_i : '0;
    bp.pht_we_o = e.v && is_br;
    bp.pht_waddr_o = e.v ? e.pa : '0;
    bp.pht_increment_o = e.v && taken_e_i;
    bp.ghr_reset_o = mispredict_o && is_br;
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      branch_count_o <= '0;
      mispredict_count_o <= '0;
    end else begin
      branch_count_o <= branch_count_o + {31'd0, bp.pht_we_o};
      mispredict_count_o <= mispredict_count_o + {31'd0, mispredict_o};
    end
  end
endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// tb_ucsbece154b_branch_resolve: directed checks of metadata pipelining, resolution and counters
module tb_ucsbece154b_branch_resolve;
  logic clk = 1'b0;
  logic reset_i, stallF_i, stallD_i, flushD_i, flushE_i;
  logic [6:0] op_e_i;
  logic taken_e_i;
  logic [31:0] target_e_i;
  logic mispredict_o;
  logic [31:0] redirect_pc_o, branch_count_o, mispredict_count_o;
  int n_cmp = 0;
  int n_bad = 0;
  logic done = 1'b0;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  ucsbece154b_branch_resolve_if bp ();
  ucsbece154b_branch_resolve dut (
    .clk(clk), .reset_i(reset_i), .stallF_i(stallF_i), .stallD_i(stallD_i),
    .flushD_i(flushD_i), .flushE_i(flushE_i), .bp(bp),
    .op_e_i(op_e_i), .taken_e_i(taken_e_i), .target_e_i(target_e_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic allzero(input string tag);
    chk({tag, " mis"}, mispredict_o, 1'b0);
    chk({tag, " redir"}, redirect_pc_o, 32'h0);
    chk({tag, " btb_we"}, bp.btb_we_o, 1'b0);
    chk({tag, " pht_we"}, bp.pht_we_o, 1'b0);
    chk({tag, " inc"}, bp.pht_increment_o, 1'b0);
    chk({tag, " ghr"}, bp.ghr_reset_o, 1'b0);
  endtask
  task automatic fdrive(input logic [31:0] pc, input logic pt, input logic [31:0] tg, input logic [4:0] pa);
    bp.pc_f_i = pc;
    bp.pred_taken_f_i = pt;
    bp.pred_target_f_i = tg;
    bp.pht_raddr_f_i = pa;
  endtask
  task automatic eidle();
    op_e_i = 7'd0;
    taken_e_i = 1'b0;
    target_e_i = 32'd0;
  endtask
  task automatic issue(input logic [31:0] pc, input logic pt, input logic [31:0] tg, input logic [4:0] pa);
    @(negedge clk);
    fdrive(pc, pt, tg, pa);
    eidle();
    @(negedge clk);
    fdrive(32'd0, 1'b0, 32'd0, 5'd0);
    @(negedge clk);
  endtask
  initial begin
    #100000;
    if (!done) begin
      n_bad++;
      $error("FAIL timeout: simulation did not complete");
      $finish;
    end
  end
  initial begin
    stallF_i = 0; stallD_i = 0; flushD_i = 0; flushE_i = 0;
    reset_i = 1;
    fdrive(32'h100, 1'b1, 32'h80, 5'd5);
    op_e_i = BR; taken_e_i = 1; target_e_i = 32'h999;
    repeat (2) @(negedge clk);
    #1;
    allzero("reset");
    chk("reset bcnt", branch_count_o, 32'd0);
    chk("reset mcnt", mispredict_count_o, 32'd0);
    reset_i = 0;
    fdrive(32'd0, 1'b0, 32'd0, 5'd0);
    eidle();
    issue(32'h100, 1'b1, 32'h80, 5'd5);
    op_e_i = BR; taken_e_i = 1; target_e_i = 32'h80; #1;
    chk("t2 pht_we", bp.pht_we_o, 1'b1);
    chk("t2 pht_waddr", bp.pht_waddr_o, 5'd5);
    chk("t2 inc", bp.pht_increment_o, 1'b1);
    chk("t2 mis", mispredict_o, 1'b0);
    chk("t2 btb_we", bp.btb_we_o, 1'b0);
    chk("t2 ghr", bp.ghr_reset_o, 1'b0);
    chk("t2 redir", redirect_pc_o, 32'h0);
    @(negedge clk); eidle(); #1;
    chk("t2 bcnt", branch_count_o, 32'd1);
    chk("t2 mcnt", mispredict_count_o, 32'd0);
    issue(32'h104, 1'b0, 32'h0, 5'd0);
    op_e_i = BR; taken_e_i = 1; target_e_i = 32'h40; #1;
    chk("t3 mis", mispredict_o, 1'b1);
    chk("t3 redir", redirect_pc_o, 32'h40);
    chk("t3 btb_we", bp.btb_we_o, 1'b1);
    chk("t3 waddr", bp.btb_waddr_o, 5'd1);
    chk("t3 wdata", bp.btb_wdata_o, 32'h40);
    chk("t3 ghr", bp.ghr_reset_o, 1'b1);
    chk("t3 inc", bp.pht_increment_o, 1'b1);
    chk("t3 pht_we", bp.pht_we_o, 1'b1);
    @(negedge clk); eidle(); #1;
    chk("t3 bcnt", branch_count_o, 32'd2);
    chk("t3 mcnt", mispredict_count_o, 32'd1);
    issue(32'h200, 1'b1, 32'h500, 5'd7);
    op_e_i = BR; taken_e_i = 0; target_e_i = 32'h500; #1;
    chk("t4 mis", mispredict_o, 1'b1);
    chk("t4 redir", redirect_pc_o, 32'h204);
    chk("t4 btb_we", bp.btb_we_o, 1'b0);
    chk("t4 inc", bp.pht_increment_o, 1'b0);
    chk("t4 ghr", bp.ghr_reset_o, 1'b1);
    chk("t4 pht_waddr", bp.pht_waddr_o, 5'd7);
    @(negedge clk); eidle(); #1;
    chk("t4 bcnt", branch_count_o, 32'd3);
    chk("t4 mcnt", mispredict_count_o, 32'd2);
    issue(32'h10C, 1'b1, 32'h300, 5'd3);
    op_e_i = JAL; taken_e_i = 0; target_e_i = 32'h340; #1;
    chk("t5 mis", mispredict_o, 1'b1);
    chk("t5 redir", redirect_pc_o, 32'h340);
    chk("t5 btb_we", bp.btb_we_o, 1'b1);
    chk("t5 waddr", bp.btb_waddr_o, 5'd3);
    chk("t5 wdata", bp.btb_wdata_o, 32'h340);
    chk("t5 pht_we", bp.pht_we_o, 1'b0);
    chk("t5 ghr", bp.ghr_reset_o, 1'b0);
    @(negedge clk); eidle(); #1;
    chk("t5 bcnt", branch_count_o, 32'd3);
    chk("t5 mcnt", mispredict_count_o, 32'd3);
    issue(32'h110, 1'b1, 32'h600, 5'd2);
    op_e_i = JALR; taken_e_i = 0; target_e_i = 32'h600; #1;
    chk("jalr mis", mispredict_o, 1'b0);
    chk("jalr btb_we", bp.btb_we_o, 1'b0);
    chk("jalr pht_we", bp.pht_we_o, 1'b0);
    issue(32'hFFFF_FFFC, 1'b1, 32'h10, 5'd31);
    op_e_i = BR; taken_e_i = 0; target_e_i = 32'h10; #1;
    chk("wrap mis", mispredict_o, 1'b1);
    chk("wrap redir", redirect_pc_o, 32'h0);
    chk("wrap waddr", bp.btb_waddr_o, 5'd31);
    @(negedge clk); eidle(); #1;
    chk("wrap bcnt", branch_count_o, 32'd4);
    chk("wrap mcnt", mispredict_count_o, 32'd4);
    @(negedge clk);
    fdrive(32'h400, 1'b0, 32'h0, 5'd9);
    @(negedge clk);
    fdrive(32'd0, 1'b0, 32'd0, 5'd0);
    stallD_i = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      op_e_i = BR; taken_e_i = 1; target_e_i = 32'h44; #1;
      allzero("stall");
      chk("stall bcnt", branch_count_o, 32'd4);
      chk("stall mcnt", mispredict_count_o, 32'd4);
    end
    stallD_i = 0;
    @(negedge clk); #1;
    chk("held mis", mispredict_o, 1'b1);
    chk("held pht_waddr", bp.pht_waddr_o, 5'd9);
    chk("held waddr", bp.btb_waddr_o, 5'd0);
    flushE_i = 1;
    @(negedge clk); #1;
    flushE_i = 0;
    allzero("flushE");
    chk("flushE bcnt", branch_count_o, 32'd5);
    chk("flushE mcnt", mispredict_count_o, 32'd5);
    @(negedge clk);
    eidle();
    fdrive(32'h700, 1'b1, 32'h900, 5'd4);
    flushD_i = 1;
    @(negedge clk);
    flushD_i = 0;
    fdrive(32'd0, 1'b0, 32'd0, 5'd0);
    @(negedge clk);
    op_e_i = BR; taken_e_i = 1; target_e_i = 32'h44; #1;
    allzero("flushD");
    @(negedge clk);
    eidle();
    fdrive(32'h800, 1'b0, 32'h0, 5'd6);
    @(negedge clk);
    fdrive(32'd0, 1'b0, 32'd0, 5'd0);
    reset_i = 1;
    @(negedge clk);
    @(negedge clk);
    reset_i = 0;
    op_e_i = BR; taken_e_i = 1; target_e_i = 32'h44; #1;
    allzero("post-reset");
    chk("post-reset bcnt", branch_count_o, 32'd0);
    chk("post-reset mcnt", mispredict_count_o, 32'd0);
    @(negedge clk); #1;
    allzero("post-reset2");
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ucsbece154b_branch_resolve.md
Name: ucsbece154b_branch_resolve

Overview:
- Execute-stage resolution and update unit for the gshare/BTB branch predictor; the consumer end of the predictor's fetch-side interface.
- Pipelines each fetched instruction's prediction metadata (PC, predicted taken, predicted target, PHT read address) from F through D to E.
- Compares that metadata against the actual control-flow outcome, and generates the predictor's BTB write, PHT write and GHR reset controls, plus the mispredict redirect for the hazard unit.
- Maintains 32-bit branch and mispredict statistics counters.

Parameters:
- NUM_BTB_ENTRIES, 32, BTB depth; IDX = $clog2(NUM_BTB_ENTRIES)
- NUM_GHR_BITS, 5, PHT address width

Ports:
- clk  in  1  clock
- reset_i  in  1  synchronous active-high reset
- stallF_i  in  1  unused by state; documents the F-side hold
- stallD_i  in  1  hold D-stage metadata register
- flushD_i  in  1  invalidate D-stage metadata
- flushE_i  in  1  invalidate E-stage metadata
- pc_f_i  in  32  fetch PC
- pred_taken_f_i  in  1  predictor BranchTaken for pc_f_i
- pred_target_f_i  in  32  predictor BTB target for pc_f_i
- pht_raddr_f_i  in  NUM_GHR_BITS  predictor PHT read address for pc_f_i
- op_e_i  in  7  E-stage opcode
- taken_e_i  in  1  actual branch condition result in E
- target_e_i  in  32  actual computed target in E
- btb_we_o  out  1  BTB write enable
- btb_waddr_o  out  IDX  BTB write index
- btb_wdata_o  out  32  BTB write target
- pht_we_o  out  1  PHT write enable
- pht_waddr_o  out  NUM_GHR_BITS  PHT write address
- pht_increment_o  out  1  1 = increment counter, 0 = decrement
- ghr_reset_o  out  1  GHR reset request
- mispredict_o  out  1  redirect required
- redirect_pc_o  out  32  correct next PC
- branch_count_o  out  32  resolved conditional branches
- mispredict_count_o  out  32  mispredicts

Behaviour:
- **Metadata registers.** D and E registers each hold {valid, pc, pred_taken, pred_target, pht_addr}.
- **D register, per cycle, priority order:**
  - reset_i: clear all fields.
  - flushD_i: valid=0, pred_taken=0.
  - stallD_i: hold.
  - Otherwise: load the F inputs with valid=1.
- **E register, per cycle, priority order:**
  - reset_i: clear all fields.
  - flushE_i: clear; flushE_i wins over everything except reset.
  - stallD_i: load a bubble (valid=0).
  - Otherwise: load from D.
- **Decode in E:**
  - is_br = (op_e_i==7'b1100011)
  - is_j = (op_e_i==7'b1101111 or op_e_i==7'b1100111)
  - act_taken = is_br ? taken_e_i : is_j
- **Outputs, all combinational from the E register; every output is 0 while E is invalid and after reset:**
  - mispredict_o = valid_e && (pred_taken_e != act_taken || (act_taken && pred_target_e != target_e_i))
  - redirect_pc_o = act_taken ? target_e_i : pc_e + 4; 32-bit wrap; 0 when mispredict_o=0.
  - btb_we_o = valid_e && act_taken && (is_br||is_j) && (!pred_taken_e || pred_target_e != target_e_i)
  - btb_waddr_o = pc_e[IDX+1:2]
  - btb_wdata_o = target_e_i
  - pht_we_o = valid_e && is_br
  - pht_waddr_o = pht_addr_e
  - pht_increment_o = taken_e_i
  - ghr_reset_o = mispredict_o && is_br
- **Counters:**
  - branch_count_o increments when pht_we_o=1.
  - mispredict_count_o increments when mispredict_o=1.
  - Both wrap 0xFFFFFFFF to 0.
  - Both clear on reset_i.
- **No self-flush.** The block does not flush itself. The hazard unit consumes mispredict_o and asserts flushD_i/flushE_i on the following edge.
- **Single retire.** Each E entry is resolved and counted exactly once.
- **Reset mid-operation.** Every in-flight entry is discarded; no update outputs fire in the cycle after reset.

Test Plan:
1. **Reset.** Reset 2 cycles with live F inputs -> all outputs 0, counters 0.
2. **Correct taken branch.** pc_f=0x100, pred_taken=1, pred_target=0x80, pht_raddr=5; two cycles later op_e=1100011, taken_e=1, target_e=0x80 -> pht_we=1, addr=5, inc=1, mispredict=0, btb_we=0, branch_count=1.
3. **Not-predicted taken branch.** pc=0x104, pred_taken=0, taken_e=1, target_e=0x40 -> mispredict=1, redirect=0x40, btb_we=1, waddr=1, wdata=0x40, ghr_reset=1, pht inc=1.
4. **Wrongly predicted taken.** pred_taken=1, taken_e=0, pc=0x200 -> mispredict=1, redirect=0x204, btb_we=0, pht inc=0, ghr_reset=1.
5. **JAL with stale BTB target.** pred_target=0x300, target_e=0x340 -> mispredict=1, btb_we=1, pht_we=0, ghr_reset=0.
6. **Stall and flush.** stallD_i held 3 cycles -> E sees bubbles, no outputs, counters unchanged. flushE_i asserted on a mispredicting entry -> next cycle all outputs 0.
